// File: rtl/motoro_sixstep_if.sv
// Control inputs and gate-drive outputs of the six-step generator.
interface motoro_sixstep_if #(
  parameter int FREQ_W = 10
);
  logic              m3start;
  logic              m3stop;
  logic              m3dir;
  logic [FREQ_W-1:0] m3freq;
  logic              aHP, bHP, cHP;
  logic              aLN, bLN, cLN;
  logic [2:0]        m3step;
  logic              m3stepPulse;
  logic              m3running;
  logic              m3atSpeed;

  modport master (
    output m3start, m3stop, m3dir, m3freq,
    input  aHP, bHP, cHP, aLN, bLN, cLN,
    input  m3step, m3stepPulse, m3running, m3atSpeed
  );

  modport slave (
    input  m3start, m3stop, m3dir, m3freq,
    output aHP, bHP, cHP, aLN, bLN, cLN,
    output m3step, m3stepPulse, m3running, m3atSpeed
  );
endinterface

// File: rtl/motoro_sixstep_gen.sv
// Six-step three-phase commutation generator with soft-start ramp,
// direction select and per-switch turn-on dead time.
module motoro_sixstep_gen #(
  parameter int FREQ_W     = 10,
  parameter int PRESC      = 500,
  parameter int DEAD       = 25,
  parameter int RAMP_START = 1023,
  parameter int RAMP_STEP  = 8,
  parameter int HP_INV     = 0
) (
  input  logic            clk50mhz,
  input  logic            nReset,
  motoro_sixstep_if.slave io
);
  typedef enum logic [1:0] {IDLE, RAMP, RUN} state_e;

  localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam int DW = (DEAD > 1) ? $clog2(DEAD) : 1;
  localparam logic [FREQ_W-1:0] RS = FREQ_W'(RAMP_START);
  localparam logic [FREQ_W-1:0] RD = FREQ_W'(RAMP_STEP);
  localparam logic [PW-1:0] PMAX = PW'(PRESC - 1);
  localparam logic [DW-1:0] DMAX = DW'(DEAD - 1);
  localparam logic HPI = (HP_INV != 0);

  state_e            state_q, state_d;
  logic              dir_q, dir_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [FREQ_W-1:0] cnt_q, cnt_d;
  logic [FREQ_W-1:0] period_q, period_d;
  logic [2:0]        step_q, step_d;
  logic              pulse_q, pulse_d;
  logic              run_q, run_d;
  logic              at_q, at_d;
  logic [5:0]        on_q, on_d;
  logic [5:0][DW-1:0] dt_q, dt_d;

  logic              go;
  logic              tick;
  logic [FREQ_W-1:0] dec;
  logic [2:0]        step_nx;
  logic [5:0]        req;

  always_comb begin
    go   = io.m3start && !io.m3stop && (io.m3freq != '0);
    tick = (presc_q == PMAX);
    dec  = (period_q > RD) ? period_q - RD : FREQ_W'(1);
    if (dir_q)
      step_nx = (step_q == 3'd0) ? 3'd5 : step_q - 3'd1;
    else
      step_nx = (step_q == 3'd5) ? 3'd0 : step_q + 3'd1;

    state_d  = state_q;
    dir_d    = dir_q;
    presc_d  = presc_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    step_d   = step_q;
    pulse_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        presc_d = '0;
        cnt_d   = '0;
        step_d  = '0;
        if (go) begin
          state_d  = RAMP;
          dir_d    = io.m3dir;
          period_d = (io.m3freq > RS) ? io.m3freq : RS;
        end
      end
      default: begin
        if (!go) begin
          state_d = IDLE;
          presc_d = '0;
          cnt_d   = '0;
          step_d  = '0;
        end else if (tick) begin
          presc_d = '0;
          if (cnt_q == period_q - FREQ_W'(1)) begin
            cnt_d   = '0;
            step_d  = step_nx;
            pulse_d = 1'b1;
            // ramp ends once the target is reached or overtaken
            if (state_q == RUN || io.m3freq >= dec) begin
              state_d  = RUN;
              period_d = io.m3freq;
            end else begin
              period_d = dec;
            end
          end else begin
            cnt_d = cnt_q + FREQ_W'(1);
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
    endcase

    run_d = (state_d != IDLE);
    at_d  = (state_d == RUN);
  end

  // req = {cLN, bLN, aLN, cHP, bHP, aHP}
  always_comb begin
    req = '0;
    if (state_q != IDLE) begin
      unique case (step_q)
        3'd0:    req = 6'b010_001;
        3'd1:    req = 6'b100_001;
        3'd2:    req = 6'b100_010;
        3'd3:    req = 6'b001_010;
        3'd4:    req = 6'b001_100;
        3'd5:    req = 6'b010_100;
        default: req = '0;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < 6; i++) begin
      on_d[i] = 1'b0;
      dt_d[i] = '0;
      if (req[i] && state_d != IDLE) begin
        if (on_q[i] || dt_q[i] == DMAX)
          on_d[i] = 1'b1;
        else
          dt_d[i] = dt_q[i] + DW'(1);
      end
    end
  end

  always_ff @(posedge clk50mhz or negedge nReset) begin
    if (!nReset) begin
      state_q  <= IDLE;
      dir_q    <= 1'b0;
      presc_q  <= '0;
      cnt_q    <= '0;
      period_q <= '0;
      step_q   <= '0;
      pulse_q  <= 1'b0;
      run_q    <= 1'b0;
      at_q     <= 1'b0;
      on_q     <= '0;
      dt_q     <= '0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      presc_q  <= presc_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      step_q   <= step_d;
      pulse_q  <= pulse_d;
      run_q    <= run_d;
      at_q     <= at_d;
      on_q     <= on_d;
      dt_q     <= dt_d;
    end
  end

  assign io.aHP         = on_q[0] ^ HPI;
  assign io.bHP         = on_q[1] ^ HPI;
  assign io.cHP         = on_q[2] ^ HPI;
  assign io.aLN         = on_q[3];
  assign io.bLN         = on_q[4];
  assign io.cLN         = on_q[5];
  assign io.m3step      = step_q;
  assign io.m3stepPulse = pulse_q;
  assign io.m3running   = run_q;
  assign io.m3atSpeed   = at_q;
endmodule
